// File: rtl/bp_counter_ctrl.sv
// Branch-prediction control stage around the counter cache.
// Fetch side: lookup -> taken/not-taken guess. Execute side: read counter,
// compute the saturated update, and write it back one cycle later through the
// registered write port. The in-flight write is forwarded to both read ports.
//
// Handshake: guess_valid and check_valid are plain qualifiers with no ready;
// the stage accepts a guess/check every cycle they are high, and a check
// always yields exactly one cache write on the following cycle.
module bp_counter_ctrl #(
    parameter int PC_WIDTH   = 32,
    parameter int LINES      = 128,
    parameter int CTR_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  guess_valid,
    input  logic [PC_WIDTH-1:0]   guess_pc,
    output logic                  guess_taken,
    input  logic                  check_valid,
    input  logic [PC_WIDTH-1:0]   check_pc,
    input  logic                  check_taken,
    input  logic                  check_predicted,
    output logic [PC_WIDTH-3:0]   cache_ra0,
    input  logic [CTR_WIDTH-1:0]  cache_dout0,
    input  logic                  cache_hit0,
    output logic [PC_WIDTH-3:0]   cache_ra1,
    input  logic [CTR_WIDTH-1:0]  cache_dout1,
    input  logic                  cache_hit1,
    output logic [PC_WIDTH-3:0]   cache_wa,
    output logic [CTR_WIDTH-1:0]  cache_din,
    output logic                  cache_we,
    input  logic                  stat_clear,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int AWIDTH = PC_WIDTH - 2;
    // Index width of the cache this stage fronts; the cache owns the indexing.
    localparam int IDX = $clog2(LINES);

    localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0]  WEAK_T   = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
    localparam logic [CTR_WIDTH-1:0]  WEAK_N   = WEAK_T - CTR_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    // Write stage registers: the pending counter update.
    logic              wq_v;
    logic [AWIDTH-1:0] wq_a;
    logic [CTR_WIDTH-1:0] wq_d;

    logic                 fwd_g;
    logic                 fwd_c;
    logic                 hit_g;
    logic                 hit_c;
    logic [CTR_WIDTH-1:0] ctr_g;
    logic [CTR_WIDTH-1:0] ctr_c;
    logic [CTR_WIDTH-1:0] ctr_next;

    // Word-aligned PCs: the two low bits never reach the cache.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, guess_pc[1:0], check_pc[1:0], IDX[0]};

    assign cache_ra0 = guess_pc[PC_WIDTH-1:2];
    assign cache_ra1 = check_pc[PC_WIDTH-1:2];

    assign cache_we  = wq_v;
    assign cache_wa  = wq_a;
    assign cache_din = wq_d;

    // Effective reads: the write committing at the next edge overrides the cache.
    always_comb begin
        fwd_g = wq_v && (wq_a == cache_ra0);
        fwd_c = wq_v && (wq_a == cache_ra1);
        hit_g = fwd_g ? 1'b1 : cache_hit0;
        ctr_g = fwd_g ? wq_d : cache_dout0;
        hit_c = fwd_c ? 1'b1 : cache_hit1;
        ctr_c = fwd_c ? wq_d : cache_dout1;
    end

    // Prediction: MSB of the counter on a hit; suppressed while in reset.
    always_comb begin
        guess_taken = 1'b0;
        if (!reset && guess_valid && hit_g) begin
            guess_taken = ctr_g[CTR_WIDTH-1];
        end
    end

    // Counter update: saturating step on a hit, weak state on a miss.
    always_comb begin
        ctr_next = WEAK_N;
        if (hit_c) begin
            if (check_taken) begin
                ctr_next = (ctr_c == CTR_MAX) ? ctr_c : ctr_c + CTR_WIDTH'(1);
            end else begin
                ctr_next = (ctr_c == '0) ? ctr_c : ctr_c - CTR_WIDTH'(1);
            end
        end else if (check_taken) begin
            ctr_next = WEAK_T;
        end
    end

    // Write stage loads every cycle; reset drops any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wq_v <= 1'b0;
            wq_a <= '0;
            wq_d <= '0;
        end else begin
            wq_v <= check_valid;
            wq_a <= cache_ra1;
            wq_d <= ctr_next;
        end
    end

    // Saturating statistics; a clear wins over a same-cycle event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (stat_clear) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (check_valid) begin
            if (branch_count != STAT_MAX) begin
                branch_count <= branch_count + STAT_WIDTH'(1);
            end
            if ((check_predicted != check_taken) && (mispredict_count != STAT_MAX)) begin
                mispredict_count <= mispredict_count + STAT_WIDTH'(1);
            end
        end
    end

endmodule
